// File: rtl/ec_data_bridge_pkg.sv
// Shared types and AXI constants for the EC-stage data bridge.
package ec_data_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrReq,
      StWrResp
   } state_e;

   localparam logic [7:0] AxiLen1       = 8'd0;
   localparam logic [1:0] AxiBurstIncr  = 2'b01;
   localparam logic       AxiLockNormal = 1'b0;
   localparam logic [3:0] AxiCacheDev   = 4'b0000;
   localparam logic [2:0] AxiProtData   = 3'b000;

   localparam logic [1:0] SizeByte = 2'd0;
   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;

   function automatic logic [2:0] axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/ec_data_bridge.sv
// Bridges one outstanding SRAM-like data request from the EC stage onto a
// single-beat AXI read or write, returning addr_ok/data_ok handshakes.
module ec_data_bridge
   import ec_data_bridge_pkg::*;
#(
   parameter int unsigned ID = 1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,

   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,

   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,

   input  logic        bvalid,
   output logic        bready
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        data_ok_q, data_ok_d;
   logic [31:0] rdata_q, rdata_d;
   logic        accept;

   // Gating with resetn keeps addr_ok low while reset is held and data_req is high.
   assign accept = resetn && (state_q == StIdle) && data_req;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      data_ok_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d  = data_addr;
               size_d  = data_size;
               wdata_d = data_wdata;
               wstrb_d = data_wstrb;
               if (data_wr) begin
                  state_d   = StWrReq;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = StRdAddr;
                  arvalid_d = 1'b1;
               end
            end
         end
         StRdAddr: begin
            if (arready) begin
               arvalid_d = 1'b0;
               state_d   = StRdData;
            end
         end
         StRdData: begin
            if (rvalid) begin
               rdata_d   = rdata;
               data_ok_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StWrReq: begin
            // AW and W complete independently; leave once both have handshaken.
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d = StWrResp;
            end
         end
         StWrResp: begin
            if (bvalid) begin
               data_ok_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign data_addr_ok = accept;
   assign data_data_ok = data_ok_q;
   assign data_rdata   = rdata_q;

   assign arid    = 4'(ID);
   assign araddr  = addr_q;
   assign arlen   = AxiLen1;
   assign arsize  = axi_size(size_q);
   assign arburst = AxiBurstIncr;
   assign arlock  = AxiLockNormal;
   assign arcache = AxiCacheDev;
   assign arprot  = AxiProtData;
   assign arvalid = arvalid_q;
   assign rready  = (state_q == StRdData);

   assign awid    = 4'(ID);
   assign awaddr  = addr_q;
   assign awlen   = AxiLen1;
   assign awsize  = axi_size(size_q);
   assign awburst = AxiBurstIncr;
   assign awlock  = AxiLockNormal;
   assign awcache = AxiCacheDev;
   assign awprot  = AxiProtData;
   assign awvalid = awvalid_q;

   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = (state_q == StWrResp);

endmodule

// File: tb/tb_ec_data_bridge.sv
// Directed self-checking bench for ec_data_bridge; inputs change 1ns after
// each rising edge and outputs are checked at that same point.
module tb_ec_data_bridge;
   import ec_data_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid, awid, arcache, awcache;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst;
   logic        arlock, awlock;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [3:0]  wstrb;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ec_data_bridge #(.ID(1)) dut (
      .clk(clk), .resetn(resetn),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
      .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until data_data_ok is seen; n = -1 if it never arrives.
   task automatic wait_data_ok(output int n);
      n = -1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (data_data_ok === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic slave_idle();
      arready = 0; rvalid = 0; rdata = '0;
      awready = 0; wready = 0; bvalid = 0;
   endtask

   task automatic test_reset();
      data_req = 1; data_wr = 0;
      #1;
      total++; if (data_addr_ok !== 1'b0) $display("FAIL rst_addr_ok got=%0b want=0", data_addr_ok); else passed++;
      total++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0)
         $display("FAIL rst_valids got=%b want=00000", {arvalid, awvalid, wvalid, rready, bready}); else passed++;
      total++; if (data_data_ok !== 1'b0 || data_rdata !== 32'h0)
         $display("FAIL rst_data got=%0b/%h want=0/00000000", data_data_ok, data_rdata); else passed++;
      total++; if (arid !== 4'd1 || arlen !== 8'd0 || arburst !== 2'b01 || wlast !== 1'b1)
         $display("FAIL rst_ties got=%h/%h/%b/%b want=1/00/01/1", arid, arlen, arburst, wlast); else passed++;
      data_req = 0;
      step();
      resetn = 1;
      step();
   endtask

   task automatic test_word_load();
      int n;
      data_req = 1; data_wr = 0; data_size = SizeWord; data_addr = 32'h1fc0_0010;
      arready = 1; rvalid = 1; rdata = 32'hdead_beef;
      #1;
      total++; if (data_addr_ok !== 1'b1) $display("FAIL ld_addr_ok got=%0b want=1", data_addr_ok); else passed++;
      step();
      data_req = 0;
      total++; if (arvalid !== 1'b1 || araddr !== 32'h1fc0_0010 || arsize !== 3'd2)
         $display("FAIL ld_ar got=%0b/%h/%0d want=1/1fc00010/2", arvalid, araddr, arsize); else passed++;
      wait_data_ok(n);
      total++; if (n !== 2) $display("FAIL ld_latency got=%0d want=2 cycles after accept edge", n); else passed++;
      total++; if (data_rdata !== 32'hdead_beef) $display("FAIL ld_rdata got=%h want=deadbeef", data_rdata); else passed++;
      step();
      total++; if (data_data_ok !== 1'b0) $display("FAIL ld_pulse_width got=%0b want=0", data_data_ok); else passed++;
      slave_idle();
   endtask

   task automatic test_byte_store();
      int n;
      int extra = 0;
      data_req = 1; data_wr = 1; data_size = SizeByte; data_addr = 32'h8000_0003;
      data_wdata = 32'h5500_0000; data_wstrb = 4'b1000;
      awready = 1; wready = 1; bvalid = 1;
      step();
      data_req = 0;
      total++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8000_0003 || awsize !== 3'd0)
         $display("FAIL st_aw got=%0b/%0b/%h/%0d want=1/1/80000003/0", awvalid, wvalid, awaddr, awsize);
      else passed++;
      total++; if (wdata !== 32'h5500_0000 || wstrb !== 4'b1000)
         $display("FAIL st_w got=%h/%b want=55000000/1000", wdata, wstrb); else passed++;
      wait_data_ok(n);
      total++; if (n !== 2) $display("FAIL st_latency got=%0d want=2", n); else passed++;
      for (int i = 0; i < 4; i++) begin
         step();
         if (data_data_ok === 1'b1) extra++;
      end
      total++; if (extra !== 0) $display("FAIL st_single_pulse got=%0d extra want=0", extra); else passed++;
      slave_idle();
   endtask

   task automatic test_aw_late();
      int n;
      data_req = 1; data_wr = 1; data_size = SizeWord; data_addr = 32'h0000_1000;
      data_wdata = 32'h0bad_f00d; data_wstrb = 4'hf;
      wready = 1;
      step();
      data_req = 0;
      step();
      wready = 0;
      total++; if (wvalid !== 1'b0 || awvalid !== 1'b1)
         $display("FAIL awl_w_drop got=w%0b/aw%0b want=w0/aw1", wvalid, awvalid); else passed++;
      step();
      step();
      total++; if (awvalid !== 1'b1 || bready !== 1'b0 || awaddr !== 32'h0000_1000)
         $display("FAIL awl_hold got=%0b/%0b/%h want=1/0/00001000", awvalid, bready, awaddr);
      else passed++;
      awready = 1;
      step();
      awready = 0;
      total++; if (awvalid !== 1'b0 || bready !== 1'b1)
         $display("FAIL awl_resp got=aw%0b/b%0b want=aw0/b1", awvalid, bready); else passed++;
      bvalid = 1;
      wait_data_ok(n);
      total++; if (n !== 1) $display("FAIL awl_done got=%0d want=1", n); else passed++;
      slave_idle();
   endtask

   task automatic test_back_to_back();
      int n;
      data_req = 1; data_wr = 0; data_size = SizeWord; data_addr = 32'h0000_0040;
      arready = 1; rvalid = 1; rdata = 32'h1122_3344;
      step();
      data_wr = 1; data_addr = 32'h0000_0080; data_wdata = 32'hcafe_babe; data_wstrb = 4'hf;
      total++; if (data_addr_ok !== 1'b0 || araddr !== 32'h0000_0040)
         $display("FAIL b2b_busy got=%0b/%h want=0/00000040", data_addr_ok, araddr); else passed++;
      step();
      step();
      total++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b1 || data_rdata !== 32'h1122_3344)
         $display("FAIL b2b_overlap got=%0b/%0b/%h want=1/1/11223344", data_data_ok, data_addr_ok, data_rdata);
      else passed++;
      awready = 1; wready = 1; bvalid = 1;
      step();
      data_req = 0;
      total++; if (data_data_ok !== 1'b0 || awvalid !== 1'b1 || awaddr !== 32'h0000_0080)
         $display("FAIL b2b_store got=%0b/%0b/%h want=0/1/00000080", data_data_ok, awvalid, awaddr);
      else passed++;
      wait_data_ok(n);
      total++; if (n !== 2) $display("FAIL b2b_store_done got=%0d want=2", n); else passed++;
      step();
      total++; if (data_data_ok !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0)
         $display("FAIL b2b_no_dup got=%0b/%0b/%0b want=0/0/0", data_data_ok, arvalid, awvalid);
      else passed++;
      slave_idle();
   endtask

   task automatic test_ar_stall();
      int n;
      int bad = 0;
      data_req = 1; data_wr = 0; data_size = SizeHalf; data_addr = 32'h1234_5678;
      step();
      for (int i = 0; i < 10; i++) begin
         if (araddr !== 32'h1234_5678 || arvalid !== 1'b1 || data_addr_ok !== 1'b0 || arsize !== 3'd1)
            bad++;
         step();
      end
      total++; if (bad !== 0) $display("FAIL ars_stable got=%0d bad cycles want=0", bad); else passed++;
      data_req = 0;
      arready = 1; rvalid = 1; rdata = 32'h0000_5678;
      step();
      arready = 0;
      wait_data_ok(n);
      total++; if (n !== 1 || data_rdata !== 32'h0000_5678)
         $display("FAIL ars_done got=%0d/%h want=1/00005678", n, data_rdata); else passed++;
      slave_idle();
   endtask

   task automatic test_reset_mid();
      int n;
      data_req = 1; data_wr = 0; data_size = SizeWord; data_addr = 32'h0000_0100;
      arready = 1;
      step();
      data_req = 0;
      step();
      total++; if (rready !== 1'b1) $display("FAIL rm_rd_data got=%0b want=1", rready); else passed++;
      data_req = 1;
      #2 resetn = 0;
      #1;
      total++; if (rready !== 1'b0 || arvalid !== 1'b0 || data_addr_ok !== 1'b0 || data_data_ok !== 1'b0)
         $display("FAIL rm_async got=%0b/%0b/%0b/%0b want=0/0/0/0", rready, arvalid, data_addr_ok, data_data_ok);
      else passed++;
      total++; if (data_rdata !== 32'h0) $display("FAIL rm_rdata got=%h want=00000000", data_rdata); else passed++;
      step();
      resetn = 1;
      data_addr = 32'h0000_0200; rvalid = 1; rdata = 32'hcafe_f00d;
      #1;
      total++; if (data_addr_ok !== 1'b1) $display("FAIL rm_reaccept got=%0b want=1", data_addr_ok); else passed++;
      step();
      data_req = 0;
      total++; if (araddr !== 32'h0000_0200) $display("FAIL rm_araddr got=%h want=00000200", araddr); else passed++;
      wait_data_ok(n);
      total++; if (n !== 2 || data_rdata !== 32'hcafe_f00d)
         $display("FAIL rm_load got=%0d/%h want=2/cafef00d", n, data_rdata); else passed++;
      slave_idle();
   endtask

   initial begin
      resetn = 0;
      data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
      slave_idle();
      test_reset();
      test_word_load();
      test_byte_store();
      test_aw_late();
      test_back_to_back();
      test_ar_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
